// File: rtl/reglist_sequencer_pkg.sv
// Shared encodings for the Thumb register-list sequencer (PUSH/POP/STMIA/LDMIA).
package reglist_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_STMIA = 2'b00,
    OP_LDMIA = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_WB,
    S_DONE
  } state_e;

  localparam logic [3:0] SP_I = 4'd13;
  localparam logic [3:0] LR_I = 4'd14;
  localparam logic [3:0] PC_I = 4'd15;
  localparam int         WORD = 4;

  // List bit 8 is LR when pushing and PC when popping; bits 0..7 map straight through.
  function automatic logic [3:0] map_reg(op_e op, logic [3:0] bit_idx);
    if (bit_idx == 4'd8) return (op == OP_PUSH) ? LR_I : PC_I;
    return bit_idx;
  endfunction

endpackage

// File: rtl/reglist_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a 9-bit register list.
module lowest_set_bit (
  input  logic [8:0] list,
  output logic [3:0] idx,
  output logic       any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Scan downwards so the lowest set bit is the last one to win.
    for (int i = 8; i >= 0; i--) begin
      if (list[i]) begin
        idx = 4'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reglist_sequencer.sv
// Multi-cycle register-list sequencer: one word access per listed register, then SP/base writeback.
import reglist_sequencer_pkg::*;

module reglist_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [8:0]        reg_list,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        base_idx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_wr,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              sp_wr,
  output logic [ADDR_W-1:0] sp_wdata,
  output logic              pc_wr,
  output logic [DATA_W-1:0] pc_wdata
);

  state_e            state;
  op_e               op_q;
  logic [8:0]        list_q, orig_q;
  logic [ADDR_W-1:0] base_q, end_q, addr_q;
  logic [3:0]        bidx_q;
  logic              wb_wr;
  logic [3:0]        wb_waddr;
  logic [DATA_W-1:0] wb_wdata;

  logic [3:0]        cnt;
  logic [ADDR_W-1:0] span, lo_addr, hi_addr;
  logic [3:0]        lsb_idx, cur_reg;
  logic              lsb_any, ld_ack, pc_slot;

  lowest_set_bit u_lsb (
    .list(list_q),
    .idx (lsb_idx),
    .any (lsb_any)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 9; i++) cnt = cnt + {3'b000, list_q[i]};
  end

  assign span    = ADDR_W'({cnt, 2'b00});
  assign lo_addr = base_q - span;
  assign hi_addr = base_q + span;
  assign cur_reg = map_reg(op_q, lsb_idx);

  // Loads retire straight into the register file in the ack cycle.
  assign ld_ack  = (state == S_XFER) && mem_req && mem_ack && !mem_we;
  assign pc_slot = (op_q == OP_POP) && (lsb_idx == 4'd8);

  assign mem_addr  = addr_q;
  assign mem_wdata = (mem_req && mem_we) ? rf_rdata : '0;
  assign rf_addr   = (state == S_XFER) ? cur_reg : '0;
  assign rf_wr     = (ld_ack && !pc_slot) || wb_wr;
  assign rf_waddr  = ld_ack ? cur_reg : wb_waddr;
  assign rf_wdata  = ld_ack ? mem_rdata : wb_wdata;
  assign pc_wr     = ld_ack && pc_slot;
  assign pc_wdata  = pc_wr ? {mem_rdata[DATA_W-1:1], 1'b0} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= OP_STMIA;
      list_q   <= '0;
      orig_q   <= '0;
      base_q   <= '0;
      bidx_q   <= '0;
      end_q    <= '0;
      addr_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      sp_wr    <= 1'b0;
      sp_wdata <= '0;
      wb_wr    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q   <= op_e'(op);
          list_q <= op[1] ? reg_list : {1'b0, reg_list[7:0]};
          orig_q <= op[1] ? reg_list : {1'b0, reg_list[7:0]};
          base_q <= base;
          bidx_q <= base_idx;
          busy   <= 1'b1;
          state  <= S_SETUP;
        end
        S_SETUP: if (cnt == '0) begin
          done  <= 1'b1;
          err   <= 1'b1;
          state <= S_DONE;
        end else begin
          addr_q  <= (op_q == OP_PUSH) ? lo_addr : base_q;
          end_q   <= (op_q == OP_PUSH) ? lo_addr : hi_addr;
          mem_req <= 1'b1;
          mem_we  <= (op_q == OP_STMIA) || (op_q == OP_PUSH);
          state   <= S_XFER;
        end
        S_XFER: if (mem_req) begin
          if (mem_ack) begin
            mem_req         <= 1'b0;
            list_q[lsb_idx] <= 1'b0;
            addr_q          <= addr_q + ADDR_W'(WORD);
          end
        end else if (lsb_any) begin
          mem_req <= 1'b1;
        end else begin
          // Base writeback uses the sampled base; a loaded Rn suppresses it.
          mem_we <= 1'b0;
          state  <= S_WB;
          if (op_q[1]) begin
            sp_wr    <= 1'b1;
            sp_wdata <= end_q;
          end else if (op_q == OP_STMIA || bidx_q[3] || !orig_q[bidx_q]) begin
            wb_wr    <= 1'b1;
            wb_waddr <= bidx_q;
            wb_wdata <= DATA_W'(end_q);
          end
        end
        S_WB: begin
          sp_wr    <= 1'b0;
          sp_wdata <= '0;
          wb_wr    <= 1'b0;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reglist_sequencer.sv
// Random and directed checks of reglist_sequencer against a transaction-list reference model.
module tb_reglist_sequencer;

  logic        clk, rst_n, start;
  logic [1:0]  op;
  logic [8:0]  reg_list;
  logic [31:0] base;
  logic [3:0]  base_idx;
  logic        busy, done, err, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rf_rdata, rf_wdata, sp_wdata, pc_wdata;
  logic [3:0]  rf_addr, rf_waddr;
  logic        rf_wr, sp_wr, pc_wr;

  reglist_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .reg_list(reg_list), .base(base),
    .base_idx(base_idx), .busy(busy), .done(done), .err(err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_wr(rf_wr),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sp_wr(sp_wr), .sp_wdata(sp_wdata),
    .pc_wr(pc_wr), .pc_wdata(pc_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [3:0] rg; } acc_t;

  logic [31:0] rf_vals [16];
  logic [31:0] mem_model [logic [31:0]];
  assign rf_rdata = rf_vals[rf_addr];

  acc_t        exp_q[$];
  logic        exp_we, exp_err;
  int          exp_n, wb_kind, wb_seen;
  logic [3:0]  wb_idx;
  logic [31:0] wb_val;
  bit          in_op;
  int          cyc, waits;
  int          checks = 0, fails = 0;
  logic [31:0] last_sp, last_pc, last_ld;
  int          last_lat;
  logic        last_err;
  int          ack_mode;
  bit          spurious;
  bit          resp_active;
  int          resp_cnt, resp_dly;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected accesses and writeback straight from the op's register-list rules.
  task automatic build_model(input logic [1:0] o, input logic [8:0] l, input logic [31:0] b,
                             input logic [3:0] bi);
    logic [8:0]  eff;
    logic [31:0] a0;
    int          k;
    eff   = o[1] ? l : {1'b0, l[7:0]};
    exp_n = $countones(eff);
    a0    = (o == 2'b10) ? b - 32'(4 * exp_n) : b;
    exp_q.delete();
    k = 0;
    for (int i = 0; i < 9; i++) begin
      if (eff[i]) begin
        acc_t a;
        a.addr = a0 + 32'(4 * k);
        a.rg   = (i == 8) ? ((o == 2'b10) ? 4'd14 : 4'd15) : 4'(i);
        exp_q.push_back(a);
        k++;
      end
    end
    exp_we  = (o == 2'b00) || (o == 2'b10);
    exp_err = (exp_n == 0);
    wb_kind = 0;
    wb_idx  = bi;
    wb_val  = 32'h0;
    if (exp_n != 0) begin
      if (o == 2'b10) begin wb_kind = 1; wb_val = b - 32'(4 * exp_n); end
      else if (o == 2'b11) begin wb_kind = 1; wb_val = b + 32'(4 * exp_n); end
      else begin
        wb_val  = b + 32'(4 * exp_n);
        wb_kind = 2;
        if (o == 2'b01 && bi < 4'd8) begin
          if (eff[bi]) wb_kind = 0;
        end
      end
    end
  endtask

  // Memory responder: ack after 0, 3 or a random number of cycles, optional stray acks.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; resp_active = 0; resp_cnt = 0; resp_dly = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!resp_active) begin
          resp_active = 1;
          resp_cnt    = 0;
          resp_dly    = (ack_mode == 0) ? 0 : (ack_mode == 1) ? 3 : int'($urandom_range(0, 3));
        end else resp_cnt++;
        mem_ack = (resp_cnt == resp_dly);
        if (mem_ack && !mem_we)
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : $urandom;
      end else begin
        resp_active = 0;
        mem_ack     = spurious && ($urandom_range(0, 1) == 1);
        mem_rdata   = $urandom;
      end
    end
  end

  // Per-cycle compare process.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) continue;
      if (!in_op) begin
        chk("idle_busy", 32'(busy), 0);
        chk("idle_req", 32'(mem_req), 0);
        chk("idle_done", 32'({done, err}), 0);
        chk("idle_wr", 32'({rf_wr, sp_wr, pc_wr}), 0);
      end else begin
        chk("busy", 32'(busy), 32'(cyc >= 1));
        if (mem_req) begin
          if (exp_q.size() == 0) chk("extra_req", 32'(mem_req), 0);
          else begin
            chk("mem_addr", mem_addr, exp_q[0].addr);
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) begin
              chk("rf_addr", 32'(rf_addr), 32'(exp_q[0].rg));
              chk("mem_wdata", mem_wdata, rf_vals[exp_q[0].rg]);
            end
            if (mem_ack) begin
              if (exp_we) begin
                mem_model[exp_q[0].addr] = rf_vals[exp_q[0].rg];
                chk("st_nowr", 32'({rf_wr, sp_wr, pc_wr}), 0);
              end else if (exp_q[0].rg == 4'd15) begin
                chk("pc_slot", 32'({rf_wr, pc_wr}), 32'b01);
                chk("pc_wdata", pc_wdata, {mem_rdata[31:1], 1'b0});
                last_pc = pc_wdata;
              end else begin
                chk("ld_slot", 32'({rf_wr, pc_wr}), 32'b10);
                chk("ld_waddr", 32'(rf_waddr), 32'(exp_q[0].rg));
                chk("ld_wdata", rf_wdata, mem_rdata);
                last_ld = rf_wdata;
              end
              void'(exp_q.pop_front());
            end else waits++;
          end
        end
        if (!(mem_req && mem_ack && !mem_we) && (rf_wr || sp_wr || pc_wr)) begin
          wb_seen++;
          chk("wb_kind", 32'({pc_wr, sp_wr, rf_wr}),
              (wb_kind == 1) ? 32'b010 : (wb_kind == 2) ? 32'b001 : 32'b000);
          if (sp_wr) begin chk("sp_wdata", sp_wdata, wb_val); last_sp = sp_wdata; end
          if (rf_wr) begin
            chk("wb_waddr", 32'(rf_waddr), 32'(wb_idx));
            chk("wb_wdata", rf_wdata, wb_val);
          end
          chk("wb_early", 32'(exp_q.size()), 0);
        end
        if (done) begin
          chk("latency", 32'(cyc), (exp_n == 0) ? 32'd2 : 32'(2 * exp_n + 3 + waits));
          chk("err", 32'(err), 32'(exp_err));
          chk("wb_count", 32'(wb_seen), 32'(wb_kind != 0));
          chk("left", 32'(exp_q.size()), 0);
          last_lat = cyc;
          last_err = err;
          in_op    = 0;
        end else if (err) chk("err_nodone", 32'(err), 0);
        cyc++;
        if (in_op && cyc > 300) begin chk("timeout", 0, 1); in_op = 0; end
      end
    end
  end

  task automatic launch_op(input logic [1:0] o, input logic [8:0] l, input logic [31:0] b,
                           input logic [3:0] bi);
    for (int i = 0; i < 16; i++) rf_vals[i] = $urandom;
    build_model(o, l, b, bi);
    @(negedge clk);
    op = o; reg_list = l; base = b; base_idx = bi; start = 1'b1;
    cyc = 0; waits = 0; wb_seen = 0; in_op = 1;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); reg_list = 9'($urandom); base = $urandom;
    base_idx = 4'($urandom);
  endtask

  task automatic finish_op(input bit poke);
    if (poke && exp_n >= 2) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 400 && in_op; i++) @(negedge clk);
    if (in_op) begin chk("op_bound", 0, 1); in_op = 0; end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [8:0] l, input logic [31:0] b,
                        input logic [3:0] bi, input bit poke);
    launch_op(o, l, b, bi);
    finish_op(poke);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; reg_list = '0; base = '0; base_idx = '0;
    in_op = 0; ack_mode = 0; spurious = 0;
    for (int i = 0; i < 16; i++) rf_vals[i] = '0;
    #12;
    chk("rst_outs", 32'({busy, done, err, mem_req, mem_we, rf_wr, sp_wr, pc_wr}), 0);
    chk("rst_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // PUSH {R0,R2,LR}
    build_model(2'b10, 9'h105, 32'h2000_0100, 4'd0);
    chk("model_push_a0", exp_q[0].addr, 32'h2000_00F4);
    chk("model_push_a2", exp_q[2].addr, 32'h2000_00FC);
    chk("model_push_r2", 32'(exp_q[2].rg), 32'd14);
    run_op(2'b10, 9'h105, 32'h2000_0100, 4'd0, 1'b0);
    chk("push_sp", last_sp, 32'h2000_00F4);
    chk("push_lat", 32'(last_lat), 32'd9);

    // POP {R1,PC}
    mem_model[32'h2000_00F8] = 32'h0000_0011;
    mem_model[32'h2000_00FC] = 32'h0000_0201;
    run_op(2'b11, 9'h102, 32'h2000_00F8, 4'd0, 1'b0);
    chk("pop_r1", last_ld, 32'h11);
    chk("pop_pc", last_pc, 32'h200);
    chk("pop_sp", last_sp, 32'h2000_0100);

    // LDMIA R2!,{R2,R3}: loaded Rn wins, no writeback
    build_model(2'b01, 9'h00C, 32'h100, 4'd2);
    chk("model_ldm_wb", 32'(wb_kind), 0);
    chk("model_ldm_a1", exp_q[1].addr, 32'h104);
    run_op(2'b01, 9'h00C, 32'h100, 4'd2, 1'b0);

    // STMIA R1!,{R0}: R1 <- base+4
    build_model(2'b00, 9'h001, 32'h300, 4'd1);
    chk("model_stm_wb", wb_val, 32'h304);
    run_op(2'b00, 9'h001, 32'h300, 4'd1, 1'b0);

    // Empty list, and STM/LDM with only bit 8 set (effectively empty)
    run_op(2'b10, 9'h000, 32'h1000, 4'd0, 1'b0);
    chk("empty_lat", 32'(last_lat), 32'd2);
    chk("empty_err", 32'(last_err), 32'd1);
    run_op(2'b00, 9'h100, 32'h1000, 4'd3, 1'b0);
    chk("bit8_stm_err", 32'(last_err), 32'd1);

    // Three-wait acks, stray acks outside transfers
    ack_mode = 1; spurious = 1;
    run_op(2'b10, 9'h1F0, 32'h0000_0010, 4'd0, 1'b1);
    run_op(2'b01, 9'h0A5, 32'h0000_4000, 4'd9, 1'b1);

    // Reset during the second access of a PUSH
    ack_mode = 0; spurious = 0;
    launch_op(2'b10, 9'h105, 32'h2000_0100, 4'd0);
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
        @(negedge clk);
        #3;
        if (exp_q.size() == 2 && mem_req) hit = 1;
      end
      chk("rst_reach", 32'(hit), 1);
    end
    in_op = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({busy, done, mem_req, rf_wr, sp_wr, pc_wr}), 0);
    chk("rst_mid_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 9'h081, 32'h5000, 4'd4, 1'b0);

    // Randomized phase
    for (int t = 0; t < 60; t++) begin
      logic [8:0]  l;
      logic [31:0] b;
      ack_mode = int'($urandom_range(0, 2));
      spurious = ($urandom_range(0, 1) == 1);
      l = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 1) << 8) : 9'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 16)) : ($urandom & 32'hFFFF_FFFC);
      run_op(2'($urandom), l, b, 4'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
